// File: rtl/image_stream_ctrl_if.sv
// Signal bundle between the image stream controller and its ROMs, CNN and comparator.
// The master side is the controller; the slave side is the surrounding datapath.
interface image_stream_ctrl_if #(
    parameter int unsigned ADDR_BITS = 20
);
    logic                 start;
    logic [ADDR_BITS-1:0] rom_addr;
    logic [7:0]           rom_data;
    logic [9:0]           lbl_addr;
    logic [3:0]           lbl_data;
    logic [7:0]           pix_out;
    logic                 pix_valid;
    logic                 cnn_rst_n;
    logic                 dec_valid;
    logic [3:0]           decision;
    logic [9:0]           img_idx;
    logic [9:0]           hit_cnt;
    logic                 result_valid;
    logic                 result_hit;
    logic                 timeout_err;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, rom_data, lbl_data, dec_valid, decision,
        output rom_addr, lbl_addr, pix_out, pix_valid, cnn_rst_n, img_idx, hit_cnt,
               result_valid, result_hit, timeout_err, busy, done
    );

    modport slave (
        output start, rom_data, lbl_data, dec_valid, decision,
        input  rom_addr, lbl_addr, pix_out, pix_valid, cnn_rst_n, img_idx, hit_cnt,
               result_valid, result_hit, timeout_err, busy, done
    );
endinterface

// File: rtl/image_stream_ctrl.sv
// Streams each image from the pixel ROM into the CNN, waits for the comparator decision
// and scores it against the label ROM; all outputs are registered.
module image_stream_ctrl #(
    parameter int unsigned IMG_PIXELS  = 784,
    parameter int unsigned NUM_IMAGES  = 1000,
    parameter int unsigned ADDR_BITS   = 20,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input logic                 clk,
    input logic                 rst_n,
    image_stream_ctrl_if.master bus
);
    localparam int unsigned PW = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle, StCnnRst, StStream, StDrain, StWaitDec, StScore, StDone
    } state_e;

    state_e               state_q;
    logic [ADDR_BITS-1:0] base_q;
    logic [PW-1:0]        pix_cnt_q;
    logic [TW-1:0]        timer_q;
    logic                 rst_cnt_q;
    logic                 rd_pend_q;
    logic [3:0]           label_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            base_q           <= '0;
            pix_cnt_q        <= '0;
            timer_q          <= '0;
            rst_cnt_q        <= 1'b0;
            rd_pend_q        <= 1'b0;
            label_q          <= '0;
            bus.rom_addr     <= '0;
            bus.lbl_addr     <= '0;
            bus.pix_out      <= '0;
            bus.pix_valid    <= 1'b0;
            bus.cnn_rst_n    <= 1'b0;
            bus.img_idx      <= '0;
            bus.hit_cnt      <= '0;
            bus.result_valid <= 1'b0;
            bus.result_hit   <= 1'b0;
            bus.timeout_err  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
        end else begin
            // rom_data lags rom_addr by one cycle; pix_out registers it one cycle later still.
            rd_pend_q        <= (state_q == StStream);
            bus.pix_valid    <= rd_pend_q;
            if (rd_pend_q) begin
                bus.pix_out <= bus.rom_data;
            end
            bus.result_valid <= 1'b0;

            unique case (state_q)
                StIdle, StDone: begin
                    bus.cnn_rst_n <= 1'b1;
                    if (bus.start) begin
                        state_q         <= StCnnRst;
                        base_q          <= '0;
                        rst_cnt_q       <= 1'b0;
                        bus.img_idx     <= '0;
                        bus.lbl_addr    <= '0;
                        bus.hit_cnt     <= '0;
                        bus.timeout_err <= 1'b0;
                        bus.done        <= 1'b0;
                        bus.busy        <= 1'b1;
                        bus.cnn_rst_n   <= 1'b0;
                    end
                end
                StCnnRst: begin
                    if (!rst_cnt_q) begin
                        rst_cnt_q <= 1'b1;
                    end else begin
                        label_q       <= bus.lbl_data;
                        bus.rom_addr  <= base_q;
                        pix_cnt_q     <= '0;
                        bus.cnn_rst_n <= 1'b1;
                        state_q       <= StStream;
                    end
                end
                StStream: begin
                    if (pix_cnt_q == PW'(IMG_PIXELS - 1)) begin
                        state_q <= StDrain;
                    end else begin
                        bus.rom_addr <= bus.rom_addr + ADDR_BITS'(1);
                        pix_cnt_q    <= pix_cnt_q + PW'(1);
                    end
                end
                StDrain: begin
                    // Timer counts cycles since DRAIN so SCORE lands TIMEOUT_CYC cycles after it.
                    timer_q <= TW'(1);
                    state_q <= StWaitDec;
                end
                StWaitDec: begin
                    if (bus.dec_valid) begin
                        bus.result_valid <= 1'b1;
                        bus.result_hit   <= (bus.decision == label_q);
                        if (bus.decision == label_q && bus.hit_cnt != 10'd1023) begin
                            bus.hit_cnt <= bus.hit_cnt + 10'd1;
                        end
                        state_q <= StScore;
                    end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                        bus.result_valid <= 1'b1;
                        bus.result_hit   <= 1'b0;
                        bus.timeout_err  <= 1'b1;
                        state_q          <= StScore;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StScore: begin
                    if (bus.img_idx == 10'(NUM_IMAGES - 1)) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state_q  <= StDone;
                    end else begin
                        bus.img_idx   <= bus.img_idx + 10'd1;
                        bus.lbl_addr  <= bus.img_idx + 10'd1;
                        base_q        <= base_q + ADDR_BITS'(IMG_PIXELS);
                        rst_cnt_q     <= 1'b0;
                        bus.cnn_rst_n <= 1'b0;
                        state_q       <= StCnnRst;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule
